// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two combinational read ports, one clocked write port, synchronous clear.
// Zero-cycle read latency, no backpressure; define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Register 0 is an ordinary storage location, not hardwired to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (regWrite) begin
      mem[writeReg] <= writeData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwdActive;

  // A write landing this edge is visible on a matching read port before the edge;
  // reset suppresses forwarding because the write will be discarded.
  assign fwdActive = regWrite && !reset;

  always_comb begin
    readData1 = mem[readReg1];
    readData2 = mem[readReg2];
    if (fwdActive && (readReg1 == writeReg)) begin
      readData1 = writeData;
    end
    if (fwdActive && (readReg2 == writeReg)) begin
      readData2 = writeData;
    end
  end
`else
  assign readData1 = mem[readReg1];
  assign readData2 = mem[readReg2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int checks = 0;
  int fails  = 0;

  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port should show right now, before the coming edge.
  function automatic logic [31:0] expRead(input logic [4:0] addr);
`ifdef REGFILE_BYPASS_EN
    if (regWrite && !reset && addr == writeReg) return writeData;
`endif
    return model[addr];
  endfunction

  // Apply one rising edge and advance the reference model by the same rules.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (regWrite) begin
      model[writeReg] = writeData;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; regWrite = 1'b0;
    tick();
    reset = 1'b0;
    readReg1 = 5'd0; readReg2 = 5'd31;
    #1;
    checks++;
    if (readData1 !== 32'h0) begin
      fails++; $display("FAIL reset_r0: got %h expected %h", readData1, 32'h0);
    end
    checks++;
    if (readData2 !== 32'h0) begin
      fails++; $display("FAIL reset_r31: got %h expected %h", readData2, 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      readReg1 = 5'(a); readReg2 = 5'(31 - a);
      #1;
      checks++;
      if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
        fails++; $display("FAIL reset_all a=%0d: got %h/%h expected 0", a, readData1, readData2);
      end
    end
  endtask

  task automatic test_sequential_writes();
    logic [31:0] vals [6];
    vals = '{32'h12345678, 32'h87654321, 32'hABCDEFAB, 32'h8765ABCD, 32'hA1B2C3D4, 32'hE5F67A8B};
    for (int i = 0; i < 6; i++) begin
      regWrite = 1'b1; writeReg = 5'(i + 1); writeData = vals[i];
      tick();
    end
    regWrite = 1'b0;
    for (int p = 0; p < 3; p++) begin
      readReg1 = 5'(2 * p + 1); readReg2 = 5'(2 * p + 2);
      #1;
      checks++;
      if (readData1 !== vals[2 * p]) begin
        fails++; $display("FAIL seq_port1 r%0d: got %h expected %h", 2 * p + 1, readData1, vals[2 * p]);
      end
      checks++;
      if (readData2 !== vals[2 * p + 1]) begin
        fails++; $display("FAIL seq_port2 r%0d: got %h expected %h", 2 * p + 2, readData2, vals[2 * p + 1]);
      end
    end
  endtask

  task automatic test_write_disable();
    regWrite = 1'b0; writeReg = 5'd1; writeData = 32'hFFFFFFFF;
    readReg1 = 5'd1;
    tick();
    checks++;
    if (readData1 !== 32'h12345678) begin
      fails++; $display("FAIL write_disable: got %h expected %h", readData1, 32'h12345678);
    end
  endtask

  task automatic test_reset_after_data();
    reset = 1'b1; regWrite = 1'b0;
    tick();
    reset = 1'b0;
    readReg1 = 5'd1; readReg2 = 5'd2;
    #1;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      fails++; $display("FAIL reset_after_data: got %h/%h expected 0/0", readData1, readData2);
    end
  endtask

  task automatic test_reset_priority();
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h5A5A5A5A;
    tick();
    reset = 1'b1; regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hDEADBEEF;
    readReg1 = 5'd7;
    #1;
    checks++;
    if (readData1 !== 32'h5A5A5A5A) begin
      fails++; $display("FAIL reset_prio_pre: got %h expected %h", readData1, 32'h5A5A5A5A);
    end
    tick();
    reset = 1'b0; regWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h0) begin
      fails++; $display("FAIL reset_priority: got %h expected %h", readData1, 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] preExp;
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h11111111;
    tick();
    readReg1 = 5'd9; readReg2 = 5'd9; writeReg = 5'd9;
    regWrite = 1'b1; writeData = 32'h0BADF00D;
`ifdef REGFILE_BYPASS_EN
    preExp = 32'h0BADF00D;
`else
    preExp = 32'h11111111;
`endif
    #1;
    checks++;
    if (readData1 !== preExp || readData2 !== preExp) begin
      fails++; $display("FAIL rdw_before_edge: got %h/%h expected %h", readData1, readData2, preExp);
    end
    tick();
    regWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h0BADF00D || readData2 !== 32'h0BADF00D) begin
      fails++; $display("FAIL rdw_after_edge: got %h/%h expected %h", readData1, readData2, 32'h0BADF00D);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 29) == 0);
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      // Bias reads toward the write address to exercise read-during-write.
      readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom_range(0, 31));
      readReg2  = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
      #1;
      e1 = expRead(readReg1); e2 = expRead(readReg2);
      checks++;
      if (readData1 !== e1 || readData2 !== e2) begin
        fails++; $display("FAIL random_pre n=%0d: got %h/%h expected %h/%h", n, readData1, readData2, e1, e2);
      end
      tick();
      reset = 1'b0; regWrite = 1'b0;
      #1;
      e1 = model[readReg1]; e2 = model[readReg2];
      checks++;
      if (readData1 !== e1 || readData2 !== e2) begin
        fails++; $display("FAIL random_post n=%0d: got %h/%h expected %h/%h", n, readData1, readData2, e1, e2);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; regWrite = 1'b0;
    readReg1 = 5'd0; readReg2 = 5'd0; writeReg = 5'd0; writeData = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = 'x;
    test_reset();
    test_sequential_writes();
    test_write_disable();
    test_reset_after_data();
    test_reset_priority();
    test_read_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
